// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment codes (a..g, active-high form,
// bit 6 = a), BCD digit width and the BCD-to-segment decoder.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] ZERO  = 7'b1111110;
    localparam logic [6:0] ONE   = 7'b0110000;
    localparam logic [6:0] TWO   = 7'b1101101;
    localparam logic [6:0] THREE = 7'b1111001;
    localparam logic [6:0] FOUR  = 7'b0110011;
    localparam logic [6:0] FIVE  = 7'b1011011;
    localparam logic [6:0] SIX   = 7'b1011111;
    localparam logic [6:0] SEVEN = 7'b1110000;
    localparam logic [6:0] EIGHT = 7'b1111111;
    localparam logic [6:0] NINE  = 7'b1111011;
    localparam logic [6:0] BLANK = 7'b0000000;

    // Non-BCD nibbles decode to a dark digit
    function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    bcd_to_seg = ZERO;
            4'd1:    bcd_to_seg = ONE;
            4'd2:    bcd_to_seg = TWO;
            4'd3:    bcd_to_seg = THREE;
            4'd4:    bcd_to_seg = FOUR;
            4'd5:    bcd_to_seg = FIVE;
            4'd6:    bcd_to_seg = SIX;
            4'd7:    bcd_to_seg = SEVEN;
            4'd8:    bcd_to_seg = EIGHT;
            4'd9:    bcd_to_seg = NINE;
            default: bcd_to_seg = BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick for one cycle at
// DIV-1. With DIV = 1 the counter stays at 0 and tick is high every cycle.
module seg_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Divider counter, wraps at DIV-1
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)             cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_bcd_counter_scan.sv
// DIGITS-wide BCD up/down counter with load and carry/borrow pulse, driving
// a time-multiplexed seven-segment display over one shared segment bus.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg_bcd_counter_scan
    import seg_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int COUNT_DIV       = 50_000_000,
    parameter int SCAN_DIV        = 12_500,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] cnt_out,
    output logic                      carry_out,
    output logic [6:0]                dig_out,
    output logic [DIGITS-1:0]         sel_out
);

    localparam int   IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_HIGH == 0);
    localparam logic SEL_INV = (SEL_ACTIVE_HIGH == 0);

    logic                            count_tick, scan_tick;
    logic [DIGITS-1:0][DIGIT_W-1:0]  cnt, cnt_ld, cnt_step;
    logic                            ripple_c;
    logic [DIGITS-1:0]               blank;
    logic [IDX_W-1:0]                idx;
    logic [DIGITS-1:0]               sel_nxt;
    logic [6:0]                      seg_nxt;

    seg_tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .tick   (count_tick)
    );

    seg_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk_in (clk_in),
        .rst    (rst),
        .tick   (scan_tick)
    );

    // Load value with each out-of-range nibble clamped to 9
    always_comb begin
        cnt_ld = '0;
        for (int i = 0; i < DIGITS; i++)
            cnt_ld[i] = (load_val[i*DIGIT_W +: DIGIT_W] > 4'd9) ? 4'd9
                                                                : load_val[i*DIGIT_W +: DIGIT_W];
    end

    // BCD ripple; ripple_c left set after the top digit means a full wrap
    always_comb begin
        cnt_step = cnt;
        ripple_c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple_c) begin
                if (up_dn) begin
                    if (cnt[i] == 4'd9) cnt_step[i] = 4'd0;
                    else begin
                        cnt_step[i] = cnt[i] + 4'd1;
                        ripple_c    = 1'b0;
                    end
                end else begin
                    if (cnt[i] == 4'd0) cnt_step[i] = 4'd9;
                    else begin
                        cnt_step[i] = cnt[i] - 4'd1;
                        ripple_c    = 1'b0;
                    end
                end
            end
        end
    end

    // Count register: load beats count beats hold; carry is a one-cycle pulse
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            cnt       <= cnt_ld;
            carry_out <= 1'b0;
        end else if (count_tick && en) begin
            cnt       <= cnt_step;
            carry_out <= ripple_c;
        end else begin
            carry_out <= 1'b0;
        end
    end

    assign cnt_out = cnt;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (cnt[i] == 4'd0);
            blank[i] = all_zero;
        end
    end
`else
    assign blank = '0;
`endif

    // Scan index, advances once per scan slot
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)                               idx <= '0;
        else if (scan_tick && idx == IDX_LAST)  idx <= '0;
        else if (scan_tick)                     idx <= idx + 1'b1;
    end

    // Select and segment pattern for the digit under the scan index
    always_comb begin
        sel_nxt      = '0;
        sel_nxt[idx] = 1'b1;
        seg_nxt      = blank[idx] ? BLANK : bcd_to_seg(cnt[idx]);
    end

    // Registered display drive with polarity applied; dark after reset
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            dig_out <= BLANK ^ {7{SEG_INV}};
            sel_out <= {DIGITS{SEL_INV}};
        end else begin
            dig_out <= seg_nxt ^ {7{SEG_INV}};
            sel_out <= sel_nxt ^ {DIGITS{SEL_INV}};
        end
    end

endmodule

// File: tb/tb_seg_bcd_counter_scan.sv
// Directed bench for seg_bcd_counter_scan with DIGITS=4, COUNT_DIV=8,
// SCAN_DIV=2, active-high polarities. Honours SEG_LEADING_ZERO_BLANK_EN.
module tb_seg_bcd_counter_scan;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic        en     = 1'b0;
    logic        up_dn  = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] cnt_out;
    logic        carry_out;
    logic [6:0]  dig_out;
    logic [3:0]  sel_out;

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;   // clock edges since reset release

    seg_bcd_counter_scan #(
        .DIGITS(4), .COUNT_DIV(8), .SCAN_DIV(2),
        .SEG_ACTIVE_HIGH(1), .SEL_ACTIVE_HIGH(1)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .cnt_out   (cnt_out),
        .carry_out (carry_out),
        .dig_out   (dig_out),
        .sel_out   (sel_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        ncyc++;
    endtask

    // Advance until the next edge is a count-tick edge
    task automatic goto_tick();
        while ((ncyc + 1) % 8 != 0) step();
    endtask

    // Load on an edge that is not a count tick
    task automatic do_load(input logic [15:0] v);
        if ((ncyc + 1) % 8 == 0) step();
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    // Walk 10 cycles of scan, checking select and segments against codes[]
    task automatic scan_check(input string tag, input logic [6:0] codes [4]);
        int k;
        for (int n = 0; n < 10; n++) begin
            step();
            k = ((ncyc - 1) / 2) % 4;
            chk({tag, "_sel"}, 32'(sel_out), 32'(4'b0001 << k));
            chk({tag, "_dig"}, 32'(dig_out), 32'(codes[k]));
        end
    endtask

    logic [6:0] codes_1234 [4];
    logic [6:0] codes_0070 [4];

    initial begin
        codes_1234[0] = 7'b0110011;  // 4
        codes_1234[1] = 7'b1111001;  // 3
        codes_1234[2] = 7'b1101101;  // 2
        codes_1234[3] = 7'b0110000;  // 1
`ifdef SEG_LEADING_ZERO_BLANK_EN
        codes_0070[0] = 7'b1111110;
        codes_0070[1] = 7'b1110000;
        codes_0070[2] = 7'b0000000;
        codes_0070[3] = 7'b0000000;
`else
        codes_0070[0] = 7'b1111110;
        codes_0070[1] = 7'b1110000;
        codes_0070[2] = 7'b1111110;
        codes_0070[3] = 7'b1111110;
`endif

        // Reset state
        #23;
        chk("rst_cnt",   32'(cnt_out),   32'h0);
        chk("rst_carry", 32'(carry_out), 32'h0);
        chk("rst_dig",   32'(dig_out),   32'h0);
        chk("rst_sel",   32'(sel_out),   32'h0);

        // Up count from reset release
        en = 1'b1; up_dn = 1'b1;
        @(posedge clk_in); #1;
        rst = 1'b1; ncyc = 0;
        step();
        chk("first_sel", 32'(sel_out), 32'h1);
        chk("first_dig", 32'(dig_out), 32'(7'b1111110));
        repeat (6) step();
        chk("up_7clk", 32'(cnt_out), 32'h0000);
        step();
        chk("up_8clk", 32'(cnt_out), 32'h0001);
        repeat (72) step();
        chk("up_80clk", 32'(cnt_out), 32'h0010);

        // Up wrap
        do_load(16'h9999);
        chk("ld_9999", 32'(cnt_out), 32'h9999);
        chk("ld_carry", 32'(carry_out), 32'h0);
        goto_tick(); step();
        chk("upwrap_cnt",   32'(cnt_out),   32'h0000);
        chk("upwrap_carry", 32'(carry_out), 32'h1);
        step();
        chk("upwrap_carry_off", 32'(carry_out), 32'h0);

        // Down wrap then plain decrement
        up_dn = 1'b0;
        do_load(16'h0000);
        goto_tick(); step();
        chk("dnwrap_cnt",   32'(cnt_out),   32'h9999);
        chk("dnwrap_carry", 32'(carry_out), 32'h1);
        step();
        chk("dnwrap_carry_off", 32'(carry_out), 32'h0);
        goto_tick(); step();
        chk("dn_9998",       32'(cnt_out),   32'h9998);
        chk("dn_9998_carry", 32'(carry_out), 32'h0);

        // Load clamping
        do_load(16'hA1F3);
        chk("ld_clamp", 32'(cnt_out), 32'h9193);

        // Load on a tick edge wins over the count
        goto_tick();
        load = 1'b1; load_val = 16'h4567;
        step();
        load = 1'b0;
        chk("ld_on_tick",       32'(cnt_out),   32'h4567);
        chk("ld_on_tick_carry", 32'(carry_out), 32'h0);

        // Hold across three ticks with en low
        en = 1'b0;
        repeat (3) begin goto_tick(); step(); end
        chk("en_hold", 32'(cnt_out), 32'h4567);

        // Scan of 1234
        do_load(16'h1234);
        scan_check("scan1234", codes_1234);

        // Leading-zero behaviour on 0070
        do_load(16'h0070);
        scan_check("scan0070", codes_0070);

        // Asynchronous reset mid-count
        en = 1'b1; up_dn = 1'b1;
        do_load(16'h0042);
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt",   32'(cnt_out),   32'h0);
        chk("arst_carry", 32'(carry_out), 32'h0);
        chk("arst_dig",   32'(dig_out),   32'h0);
        chk("arst_sel",   32'(sel_out),   32'h0);
        @(posedge clk_in); #1;
        chk("arst_hold", 32'(cnt_out), 32'h0);
        rst = 1'b1; ncyc = 0;
        repeat (7) step();
        chk("arst_restart0", 32'(cnt_out), 32'h0000);
        step();
        chk("arst_restart1", 32'(cnt_out), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
